// File: rtl/fp_pkg.sv
// Shared FP32 definitions for the unpack and rounding stages.
//   - field widths, bias and the all-ones exponent code
//   - unpacker FSM states and operand class enum
//   - unpk_t: unpacked operand {sign, exp, mant, class flags}
package fp_pkg;
  localparam int EXP_W     = 8;
  localparam int FRAC_W    = 23;
  localparam int GRS_W     = 3;
  localparam int MANT_W    = 27;  // {hidden, frac, G, R, S}
  localparam int EXP_OUT_W = 10;  // signed biased exponent
  localparam int BIAS      = 127;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_e;
  typedef enum logic [2:0] {ZERO, SUBNORMAL, NORMAL, INF, NAN} fp_class_e;

  typedef struct packed {
    logic                 sign;
    logic [EXP_OUT_W-1:0] exp;
    logic [MANT_W-1:0]    mant;
    logic                 is_zero;
    logic                 is_inf;
    logic                 is_nan;
    logic                 is_snan;
    logic                 is_subnormal;
  } unpk_t;
endpackage

// File: rtl/fp_classify.sv
// Combinational FP32 decode: class flags plus the initial mantissa/exponent.
//   data      : packed FP32 operand
//   res       : unpacked operand (subnormals are not yet normalized)
//   cls       : operand class
//   need_norm : operand must go through iterative normalization
// Config macro FP_DAZ_EN: subnormals decode as signed zero with
// is_subnormal still set, and never request normalization.
module fp_classify
  import fp_pkg::*;
(
  input  logic [31:0] data,
  output unpk_t       res,
  output fp_class_e   cls,
  output logic        need_norm
);
  logic [EXP_W-1:0]  e;
  logic [FRAC_W-1:0] f;

  assign e = data[30:23];
  assign f = data[22:0];

  always_comb begin
    res       = '0;
    res.sign  = data[31];
    res.mant  = {1'b1, f, {GRS_W{1'b0}}};
    res.exp   = {2'b00, e};
    cls       = NORMAL;
    need_norm = 1'b0;
    if (e == EXP_MAX) begin
      if (f == '0) begin
        cls        = INF;
        res.is_inf = 1'b1;
      end else begin
        cls         = NAN;
        res.is_nan  = 1'b1;
        res.is_snan = !f[FRAC_W-1];  // quiet bit clear => signalling
      end
    end else if (e == '0) begin
      if (f == '0) begin
        cls         = ZERO;
        res.is_zero = 1'b1;
        res.mant    = '0;
        res.exp     = '0;
      end else begin
        cls              = SUBNORMAL;
        res.is_subnormal = 1'b1;
`ifdef FP_DAZ_EN
        res.is_zero = 1'b1;
        res.mant    = '0;
        res.exp     = '0;
`else
        // Subnormals share the minimum normal exponent; NORM walks it down.
        res.mant  = {1'b0, f, {GRS_W{1'b0}}};
        res.exp   = 10'd1;
        need_norm = 1'b1;
`endif
      end
    end
  end
endmodule

// File: rtl/fp_unpacker.sv
// FP32 unpacker: classifies a packed single and emits sign, signed biased
// exponent and a 27-bit {hidden, frac, G, R, S} mantissa. Subnormals are
// normalized over several cycles, SHIFT_STEP bits per cycle (1, 2, 4 or 8).
//   clk, rst                      : clock, synchronous active-high reset
//   in_valid/in_ready/in_data     : operand handshake
//   out_valid/out_ready           : result handshake
//   out_sign/out_exp/out_mant     : unpacked result
//   out_is_{zero,inf,nan,snan,subnormal} : class flags
// Config macro FP_DAZ_EN: denormals-are-zero, no NORM state used.
module fp_unpacker
  import fp_pkg::*;
#(
  parameter int SHIFT_STEP = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sign,
  output logic [EXP_OUT_W-1:0] out_exp,
  output logic [MANT_W-1:0]    out_mant,
  output logic                 out_is_zero,
  output logic                 out_is_inf,
  output logic                 out_is_nan,
  output logic                 out_is_snan,
  output logic                 out_is_subnormal
);
  state_e    state, state_nx;
  unpk_t     r, r_nx, cls_res;
  fp_class_e cls;
  logic      need_norm;
  logic      accept;

  fp_classify u_classify (
    .data      (in_data),
    .res       (cls_res),
    .cls       (cls),
    .need_norm (need_norm)
  );

  // DONE with out_ready frees the slot in the same cycle: full throughput.
  assign in_ready  = !rst && ((state == IDLE) || (state == DONE && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);

`ifndef FP_DAZ_EN
  // Leading zeros in the top SHIFT_STEP bits, saturating at SHIFT_STEP,
  // so a step never shifts the leading one past bit 26.
  logic [3:0]        n;
  logic [MANT_W-1:0] mant_sh;
  logic              found;

  always_comb begin
    n     = 4'(SHIFT_STEP);
    found = 1'b0;
    for (int i = 0; i < SHIFT_STEP; i++) begin
      if (!found && r.mant[MANT_W-1-i]) begin
        n     = 4'(i);
        found = 1'b1;
      end
    end
    mant_sh = r.mant << n;
  end
`endif

  always_comb begin
    state_nx = state;
    r_nx     = r;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          r_nx     = cls_res;
          state_nx = need_norm ? NORM : DONE;
        end else if (state == DONE && out_ready) begin
          state_nx = IDLE;
        end
      end
      NORM: begin
`ifdef FP_DAZ_EN
        state_nx = IDLE;
`else
        r_nx.mant = mant_sh;
        r_nx.exp  = r.exp - {6'b0, n};
        if (mant_sh[MANT_W-1]) state_nx = DONE;
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      r     <= '0;
    end else begin
      state <= state_nx;
      r     <= r_nx;
    end
  end

  assign out_sign         = r.sign;
  assign out_exp          = r.exp;
  assign out_mant         = r.mant;
  assign out_is_zero      = r.is_zero;
  assign out_is_inf       = r.is_inf;
  assign out_is_nan       = r.is_nan;
  assign out_is_snan      = r.is_snan;
  assign out_is_subnormal = r.is_subnormal;
endmodule
